// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
//
// Final pipeline stage in front of the 16-entry register bank. Accepts a
// completed instruction from execute/memory, picks the ALU result or the
// returning load data, and drives the register-bank write port one cycle
// after the result is known. A per-register busy scoreboard lets decode stall
// on writes that are still in flight.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   execute-side handshake (in_ready == state IDLE)
//   in_rd, in_we        destination register and write flag
//   in_is_load          result comes from memory rather than the ALU
//   in_alu              ALU result
//   mem_rvalid/rdata    single-cycle load-data return
//   iss_mark, iss_rd    decode marks iss_rd busy at issue
//   wb_we/wb_rd/wb_data registered register-bank write port
//   busy                scoreboard, bit r = write to r pending
//   err                 sticky load-timeout flag
//
// Optional feature: define WB_TIMEOUT_EN to abandon a load after TIMEOUT
// cycles in WAIT_MEM (sets err). Without it err is tied low.
// ---------------------------------------------------------------------------
module writeback_stage #(
  parameter int BUS     = 32,
  parameter int DIR     = 4,
  parameter int PC_IDX  = 15,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIR-1:0]    in_rd,
  input  logic              in_we,
  input  logic              in_is_load,
  input  logic [BUS-1:0]    in_alu,
  input  logic              mem_rvalid,
  input  logic [BUS-1:0]    mem_rdata,
  input  logic              iss_mark,
  input  logic [DIR-1:0]    iss_rd,
  output logic              wb_we,
  output logic [DIR-1:0]    wb_rd,
  output logic [BUS-1:0]    wb_data,
  output logic [2**DIR-1:0] busy,
  output logic              err
);

  localparam int NREG = 2**DIR;
  localparam logic [DIR-1:0] PC_RD = DIR'(PC_IDX);

  typedef enum logic [0:0] {IDLE, WAIT_MEM} state_e;

  state_e            state_q, state_d;
  logic [DIR-1:0]    lrd_q, lrd_d;
  logic              lwe_q, lwe_d;
  logic              wb_we_q, wb_we_d;
  logic [DIR-1:0]    wb_rd_q, wb_rd_d;
  logic [BUS-1:0]    wb_data_q, wb_data_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              tmo_clr;

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  // Next-state and write-port selection
  always_comb begin
    state_d   = state_q;
    lrd_d     = lrd_q;
    lwe_d     = lwe_q;
    wb_we_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    tmo_clr   = 1'b0;
`ifdef WB_TIMEOUT_EN
    cnt_d     = '0;
    err_d     = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_is_load) begin
            lrd_d   = in_rd;
            lwe_d   = in_we;
            state_d = WAIT_MEM;
          end else begin
            wb_we_d   = in_we && (in_rd != PC_RD);
            wb_rd_d   = in_rd;
            wb_data_d = in_alu;
          end
        end
      end
      WAIT_MEM: begin
        // rvalid wins over a timeout on the same edge
        if (mem_rvalid) begin
          wb_we_d   = lwe_q && (lrd_q != PC_RD);
          wb_rd_d   = lrd_q;
          wb_data_d = mem_rdata;
          state_d   = IDLE;
        end
`ifdef WB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          tmo_clr = lwe_q;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Scoreboard: clears first so a same-edge mark on the same rd wins
    busy_d = busy_q;
    if (wb_we_d) busy_d[wb_rd_d] = 1'b0;
    if (tmo_clr) busy_d[lrd_q]   = 1'b0;
    if (iss_mark) busy_d[iss_rd] = 1'b1;
    busy_d[PC_RD] = 1'b0;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lrd_q     <= '0;
      lwe_q     <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      busy_q    <= '0;
`ifdef WB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      lrd_q     <= lrd_d;
      lwe_q     <= lwe_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      busy_q    <= busy_d;
`ifdef WB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign in_ready = (state_q == IDLE);
  assign wb_we    = wb_we_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign busy     = busy_q;
`ifdef WB_TIMEOUT_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: tasks drive scenarios and check control/timing
// inline; every expected register write is queued and matched against the
// write port by a negedge scoreboard process.
module tb_writeback_stage;

  localparam int BUS = 32;
  localparam int DIR = 4;
`ifdef WB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DIR-1:0]    in_rd = '0;
  logic              in_we = 1'b0;
  logic              in_is_load = 1'b0;
  logic [BUS-1:0]    in_alu = '0;
  logic              mem_rvalid = 1'b0;
  logic [BUS-1:0]    mem_rdata = '0;
  logic              iss_mark = 1'b0;
  logic [DIR-1:0]    iss_rd = '0;
  logic              wb_we;
  logic [DIR-1:0]    wb_rd;
  logic [BUS-1:0]    wb_data;
  logic [2**DIR-1:0] busy;
  logic              err;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [DIR-1:0] rd;
    logic [BUS-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  writeback_stage #(.BUS(BUS), .DIR(DIR), .PC_IDX(15), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_we(in_we),
    .in_is_load(in_is_load), .in_alu(in_alu),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .iss_mark(iss_mark), .iss_rd(iss_rd),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Scoreboard: every write on the bank port must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && wb_we === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_write: got rd=%0d data=%h, required no write", wb_rd, wb_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wb_rd !== e.rd || wb_data !== e.data) begin
          fails++;
          $display("FAIL sb_write: got rd=%0d data=%h, required rd=%0d data=%h",
                   wb_rd, wb_data, e.rd, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; in_is_load = 0; in_we = 0; mem_rvalid = 0; iss_mark = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    tick(); tick();
    rst = 0;
    tests++;
    if (in_ready !== 1'b1 || wb_we !== 1'b0 || wb_rd !== '0 || wb_data !== '0 ||
        busy !== '0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b we=%b rd=%0d data=%h busy=%h err=%b, required 1 0 0 0 0 0",
               in_ready, wb_we, wb_rd, wb_data, busy, err);
    end
  endtask

  task automatic test_alu();
    in_valid = 1; in_rd = 3; in_we = 1; in_alu = 32'hDEADBEEF;
    exp_q.push_back('{rd: 4'd3, data: 32'hDEADBEEF});
    tick();
    clear_inputs();
    tests++;
    if (wb_we !== 1'b1 || wb_rd !== 4'd3 || wb_data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL alu_write: got we=%b rd=%0d data=%h, required 1 3 deadbeef", wb_we, wb_rd, wb_data);
    end
    tick();
    tests++;
    if (wb_we !== 1'b0 || wb_data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL alu_pulse: got we=%b data=%h, required we=0 data held deadbeef", wb_we, wb_data);
    end
  endtask

  task automatic test_load();
    in_valid = 1; in_is_load = 1; in_rd = 5; in_we = 1; in_alu = 32'h0BAD0BAD;
    tick();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (in_ready !== 1'b0 || wb_we !== 1'b0) begin
        fails++;
        $display("FAIL load_wait%0d: got rdy=%b we=%b, required rdy=0 we=0", i, in_ready, wb_we);
      end
      if (i == 2) begin
        mem_rvalid = 1; mem_rdata = 32'h12345678;
        exp_q.push_back('{rd: 4'd5, data: 32'h12345678});
      end
      tick();
    end
    mem_rvalid = 0;
    tests++;
    if (wb_we !== 1'b1 || wb_rd !== 4'd5 || wb_data !== 32'h12345678 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL load_write: got we=%b rd=%0d data=%h rdy=%b, required 1 5 12345678 1",
               wb_we, wb_rd, wb_data, in_ready);
    end
    // stray rvalid back in IDLE must be ignored
    mem_rvalid = 1; mem_rdata = 32'hFFFF0000;
    tick();
    mem_rvalid = 0;
    tests++;
    if (wb_we !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL idle_rvalid: got we=%b rdy=%b, required we=0 rdy=1", wb_we, in_ready);
    end
  endtask

  task automatic test_scoreboard();
    iss_mark = 1; iss_rd = 7;
    tick();
    iss_mark = 0;
    tick();
    tests++;
    if (busy[7] !== 1'b1) begin
      fails++; $display("FAIL sb_set: got busy7=%b, required 1", busy[7]);
    end
    in_valid = 1; in_rd = 7; in_we = 1; in_alu = 32'h00000077;
    exp_q.push_back('{rd: 4'd7, data: 32'h00000077});
    tick();
    clear_inputs();
    tests++;
    if (busy[7] !== 1'b0) begin
      fails++; $display("FAIL sb_clear: got busy7=%b, required 0", busy[7]);
    end
    // mark and write on the same edge: mark wins
    in_valid = 1; in_rd = 7; in_we = 1; in_alu = 32'h00000078;
    iss_mark = 1; iss_rd = 7;
    exp_q.push_back('{rd: 4'd7, data: 32'h00000078});
    tick();
    clear_inputs();
    tests++;
    if (busy[7] !== 1'b1) begin
      fails++; $display("FAIL sb_set_wins: got busy7=%b, required 1", busy[7]);
    end
    // in_we=0 clears nothing and writes nothing
    in_valid = 1; in_rd = 7; in_we = 0; in_alu = 32'h00000079;
    tick();
    clear_inputs();
    tests++;
    if (busy[7] !== 1'b1 || wb_we !== 1'b0) begin
      fails++; $display("FAIL sb_no_we: got busy7=%b we=%b, required 1 0", busy[7], wb_we);
    end
    in_valid = 1; in_rd = 7; in_we = 1; in_alu = 32'h0000007A;
    exp_q.push_back('{rd: 4'd7, data: 32'h0000007A});
    tick();
    clear_inputs();
    tests++;
    if (busy !== '0) begin
      fails++; $display("FAIL sb_final: got busy=%h, required 0", busy);
    end
  endtask

  task automatic test_pc_suppress();
    in_valid = 1; in_rd = 15; in_we = 1; in_alu = 32'hCAFEF00D;
    iss_mark = 1; iss_rd = 15;
    tick();
    clear_inputs();
    tests++;
    if (wb_we !== 1'b0 || busy[15] !== 1'b0) begin
      fails++; $display("FAIL pc_suppress: got we=%b busy15=%b, required 0 0", wb_we, busy[15]);
    end
    tick();
    tests++;
    if (wb_we !== 1'b0 || busy !== '0) begin
      fails++; $display("FAIL pc_after: got we=%b busy=%h, required 0 0", wb_we, busy);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      logic [DIR-1:0] rd;
      logic [BUS-1:0] d;
      logic exp_we;
      rd = DIR'($urandom_range(0, 15));
      d  = $urandom;
      exp_we = (rd != 4'd15);
      in_valid = 1; in_rd = rd; in_we = 1; in_alu = d;
      if (exp_we) exp_q.push_back('{rd: rd, data: d});
      tick();
      tests++;
      if (wb_we !== exp_we || wb_rd !== rd || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b%0d: got we=%b rd=%0d rdy=%b, required we=%b rd=%0d rdy=1",
                 i, wb_we, wb_rd, in_ready, exp_we, rd);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_wait();
    in_valid = 1; in_is_load = 1; in_rd = 4; in_we = 1;
    iss_mark = 1; iss_rd = 4;
    tick();
    clear_inputs();
    tests++;
    if (in_ready !== 1'b0 || busy[4] !== 1'b1) begin
      fails++; $display("FAIL rw_pending: got rdy=%b busy4=%b, required 0 1", in_ready, busy[4]);
    end
    rst = 1;
    tick();
    rst = 0;
    mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
    tick();
    mem_rvalid = 0;
    tests++;
    if (wb_we !== 1'b0 || busy !== '0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rw_discard: got we=%b busy=%h rdy=%b, required 0 0 1", wb_we, busy, in_ready);
    end
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout();
    in_valid = 1; in_is_load = 1; in_rd = 2; in_we = 1;
    iss_mark = 1; iss_rd = 2;
    tick();
    clear_inputs();
    for (int i = 0; i < TMO; i++) begin
      tests++;
      if (in_ready !== 1'b0 || err !== 1'b0) begin
        fails++; $display("FAIL tmo_wait%0d: got rdy=%b err=%b, required 0 0", i, in_ready, err);
      end
      tick();
    end
    tests++;
    if (in_ready !== 1'b1 || wb_we !== 1'b0 || busy[2] !== 1'b0 || err !== 1'b1) begin
      fails++;
      $display("FAIL tmo_fire: got rdy=%b we=%b busy2=%b err=%b, required 1 0 0 1",
               in_ready, wb_we, busy[2], err);
    end
    tick(); tick();
    tests++;
    if (err !== 1'b1) begin
      fails++; $display("FAIL tmo_sticky: got err=%b, required 1", err);
    end
    rst = 1;
    tick();
    rst = 0;
    tests++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL tmo_rst: got err=%b, required 0", err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_scoreboard();
    test_pc_suppress();
    test_back_to_back();
    test_reset_wait();
`ifdef WB_TIMEOUT_EN
    test_timeout();
`endif
    tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
